// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//
// Runs the PLL start-up sequence from the reference clock. It holds the PLL
// reset for a fixed pulse, waits for lock, and requires lock to stay stable
// before it releases the core reset. If lock is lost in RUN, if lock does not
// arrive in time, or if a relock is forced, the PLL reset sequence runs again.
//
// Ports:
//   refclk        reference clock; all logic is clocked here
//   rst           asynchronous, active-high reset
//   pll_locked    PLL lock flag, asynchronous to refclk (synchronized here)
//   force_relock  level request to restart the sequence (ignored in PLL_RESET)
//   pll_rst       reset to the PLL, active high
//   core_rst      reset to downstream core logic, active high
//   ready         high while the sequencer is in RUN
//   lock_lost     one-cycle pulse when lock drops while in RUN
//   retry_count   number of lock timeouts, saturating at 15; cleared only by rst
//
// The FSM state is held in state_q so that checkers can bind to it directly.

module pll_lock_sequencer #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 262144,
  parameter int CNT_W               = 20
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       force_relock,
  output logic       pll_rst,
  output logic       core_rst,
  output logic       ready,
  output logic       lock_lost,
  output logic [3:0] retry_count
);

  typedef enum logic [1:0] {
    S_PLL_RESET = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sync_meta;
  logic             locked_s;

  // Outputs are registered and always set together with the state they
  // describe, so pll_rst/core_rst/ready change on the edge that enters a state.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q     <= S_PLL_RESET;
      cnt_q       <= '0;
      sync_meta   <= 1'b0;
      locked_s    <= 1'b0;
      pll_rst     <= 1'b1;
      core_rst    <= 1'b1;
      ready       <= 1'b0;
      lock_lost   <= 1'b0;
      retry_count <= 4'd0;
    end else begin
      // Two-flop synchronizer; the FSM looks only at locked_s.
      sync_meta <= pll_locked;
      locked_s  <= sync_meta;
      lock_lost <= 1'b0;

      // A forced relock overrides every other transition, including a
      // simultaneous lock drop (no lock_lost) or timeout (no retry increment).
      if (force_relock && (state_q != S_PLL_RESET)) begin
        state_q  <= S_PLL_RESET;
        cnt_q    <= '0;
        pll_rst  <= 1'b1;
        core_rst <= 1'b1;
        ready    <= 1'b0;
      end else begin
        case (state_q)
          S_PLL_RESET: begin
            if (cnt_q == RST_LAST) begin
              state_q <= S_WAIT_LOCK;
              cnt_q   <= '0;
              pll_rst <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end

          S_WAIT_LOCK: begin
            if (locked_s) begin
              state_q <= S_STABLE;
              cnt_q   <= '0;
            end else if (cnt_q == TIMEOUT_LAST) begin
              state_q <= S_PLL_RESET;
              cnt_q   <= '0;
              pll_rst <= 1'b1;
              if (retry_count != 4'd15) begin
                retry_count <= retry_count + 4'd1;
              end
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end

          S_STABLE: begin
            // Any synchronized low restarts both the stability window and
            // the lock timeout window.
            if (!locked_s) begin
              state_q <= S_WAIT_LOCK;
              cnt_q   <= '0;
            end else if (cnt_q == STABLE_LAST) begin
              state_q  <= S_RUN;
              cnt_q    <= '0;
              core_rst <= 1'b0;
              ready    <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end

          S_RUN: begin
            if (!locked_s) begin
              state_q   <= S_PLL_RESET;
              cnt_q     <= '0;
              pll_rst   <= 1'b1;
              core_rst  <= 1'b1;
              ready     <= 1'b0;
              lock_lost <= 1'b1;
            end
          end

          default: begin
            state_q  <= S_PLL_RESET;
            cnt_q    <= '0;
            pll_rst  <= 1'b1;
            core_rst <= 1'b1;
            ready    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer
//
// Bench for pll_lock_sequencer with short timing parameters. A reference
// model described in terms of "cycles remaining" per phase predicts the
// registered outputs after every refclk edge; those predictions go into an
// expected queue and are compared against the DUT on each falling edge.
// Directed sections steer the DUT through clean lock, lock loss, forced
// relocks coincident with drops/timeouts, unstable lock, random traffic,
// retry saturation and asynchronous reset.

module tb_pll_lock_sequencer;

  localparam int RST_PULSE = 4;
  localparam int STABLE    = 8;
  localparam int TIMEOUT   = 32;
  localparam int CNT_W     = 8;

  localparam int SEL_PLL_RST = 0;
  localparam int SEL_READY   = 1;

  // ---------------- clock / reset ----------------
  logic       refclk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       force_relock;
  logic       pll_rst;
  logic       core_rst;
  logic       ready;
  logic       lock_lost;
  logic [3:0] retry_count;

  always #5 refclk = ~refclk;

  pll_lock_sequencer #(
    .RST_PULSE_CYCLES    (RST_PULSE),
    .LOCK_STABLE_CYCLES  (STABLE),
    .LOCK_TIMEOUT_CYCLES (TIMEOUT),
    .CNT_W               (CNT_W)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .force_relock (force_relock),
    .pll_rst      (pll_rst),
    .core_rst     (core_rst),
    .ready        (ready),
    .lock_lost    (lock_lost),
    .retry_count  (retry_count)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [7:0] observed();
    return {pll_rst, core_rst, ready, lock_lost, retry_count};
  endfunction

  // ---------------- reference model ----------------
  typedef enum {P_PULSE, P_WAIT, P_SETTLE, P_RUN} phase_t;

  phase_t     m_phase;
  int         m_pulse_left;
  int         m_timeout_left;
  int         m_settle_left;
  int         m_retries;
  bit         m_lost;
  bit         m_seen;
  bit         m_sync_q[$];
  logic [7:0] exp_q[$];

  task automatic model_start_pulse();
    m_phase      = P_PULSE;
    m_pulse_left = RST_PULSE;
  endtask

  task automatic model_reset();
    model_start_pulse();
    m_retries = 0;
    m_lost    = 1'b0;
    m_sync_q.delete();
    m_sync_q.push_back(1'b0);
    m_sync_q.push_back(1'b0);
  endtask

  function automatic logic [7:0] model_expected();
    return {m_phase == P_PULSE, m_phase != P_RUN, m_phase == P_RUN, m_lost, 4'(m_retries)};
  endfunction

  // The FSM sees pll_locked as sampled two edges earlier.
  always @(posedge refclk or posedge rst) begin
    if (rst) begin
      model_reset();
      exp_q.delete();
    end else begin
      m_seen = m_sync_q.pop_front();
      m_sync_q.push_back(pll_locked);
      m_lost = 1'b0;
      case (m_phase)
        P_PULSE: begin
          m_pulse_left--;
          if (m_pulse_left == 0) begin
            m_phase        = P_WAIT;
            m_timeout_left = TIMEOUT;
          end
        end
        P_WAIT: begin
          if (force_relock) model_start_pulse();
          else if (m_seen) begin
            m_phase       = P_SETTLE;
            m_settle_left = STABLE;
          end else begin
            m_timeout_left--;
            if (m_timeout_left == 0) begin
              if (m_retries < 15) m_retries++;
              model_start_pulse();
            end
          end
        end
        P_SETTLE: begin
          if (force_relock) model_start_pulse();
          else if (!m_seen) begin
            m_phase        = P_WAIT;
            m_timeout_left = TIMEOUT;
          end else begin
            m_settle_left--;
            if (m_settle_left == 0) m_phase = P_RUN;
          end
        end
        default: begin
          if (force_relock) model_start_pulse();
          else if (!m_seen) begin
            m_lost = 1'b1;
            model_start_pulse();
          end
        end
      endcase
      exp_q.push_back(model_expected());
    end
  end

  // Scoreboard: every prediction is compared on the following falling edge.
  always @(negedge refclk) begin
    if (!rst && exp_q.size() > 0) begin
      check("cycle_outputs", observed(), exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge refclk);
  endtask

  function automatic logic get_sig(input int which);
    return (which == SEL_PLL_RST) ? pll_rst : ready;
  endfunction

  task automatic wait_until(input int which, input logic val, input int max_cyc, input string tag);
    int n = 0;
    while (get_sig(which) !== val && n < max_cyc) begin
      cycles(1);
      n++;
    end
    check(tag, get_sig(which), val);
  endtask

  // Called on the first falling edge where pll_rst is high; counts samples.
  task automatic measure_pulse(input string tag);
    int n = 0;
    while (pll_rst === 1'b1 && n < 100) begin
      cycles(1);
      n++;
    end
    check(tag, n, RST_PULSE);
  endtask

  // target < 0 means "any point in STABLE".
  task automatic wait_settle(input int target, input int max_cyc, input string tag);
    int n = 0;
    while (!(m_phase == P_SETTLE && (target < 0 || m_settle_left == target)) && n < max_cyc) begin
      cycles(1);
      n++;
    end
    check(tag, n < max_cyc, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    rst          = 1'b1;
    pll_locked   = 1'b0;
    force_relock = 1'b0;
    cycles(3);
    check("reset_outputs", observed(), 8'hC0);
    rst = 1'b0;

    // Power-up with a clean lock five cycles after pll_rst falls.
    wait_until(SEL_PLL_RST, 1'b0, 20, "pll_rst_fall");
    cycles(5);
    pll_locked = 1'b1;
    wait_until(SEL_READY, 1'b1, 40, "ready_after_lock");
    check("retry_clean_lock", retry_count, 4'd0);
    check("core_rst_in_run", core_rst, 1'b0);

    // Lock loss in RUN: lock_lost pulses with the pll_rst rise.
    cycles(4);
    pll_locked = 1'b0;
    wait_until(SEL_PLL_RST, 1'b1, 6, "relock_after_loss");
    check("lock_lost_pulse", lock_lost, 1'b1);
    measure_pulse("pulse_after_loss");
    check("lock_lost_cleared", lock_lost, 1'b0);

    // Forced relock in RUN on the same edge the synchronized lock drops.
    pll_locked = 1'b1;
    wait_until(SEL_READY, 1'b1, 40, "ready_before_force");
    pll_locked = 1'b0;
    cycles(2);
    force_relock = 1'b1;
    cycles(1);
    force_relock = 1'b0;
    check("force_run_no_lost", lock_lost, 1'b0);
    check("force_run_pll_rst", pll_rst, 1'b1);
    check("force_run_ready", ready, 1'b0);

    // Forced relock in WAIT_LOCK on the timeout edge.
    wait_until(SEL_PLL_RST, 1'b0, 10, "enter_wait");
    cycles(TIMEOUT - 1);
    force_relock = 1'b1;
    cycles(1);
    check("force_wait_pll_rst", pll_rst, 1'b1);
    check("force_wait_no_retry", retry_count, 4'd0);

    // Force held during PLL_RESET must not stretch the pulse.
    measure_pulse("pulse_with_force");
    force_relock = 1'b0;

    // Unstable lock: drop for two cycles at stability count 5.
    pll_locked = 1'b1;
    wait_settle(STABLE - 5, 60, "reach_settle_5");
    pll_locked = 1'b0;
    cycles(2);
    pll_locked = 1'b1;
    wait_until(SEL_READY, 1'b1, 60, "ready_after_glitch");
    check("retry_after_glitch", retry_count, 4'd0);

    // Random lock activity with occasional forced relocks.
    repeat (80) begin
      pll_locked   = ($urandom_range(0, 3) != 0);
      force_relock = ($urandom_range(0, 15) == 0);
      cycles(1);
      force_relock = 1'b0;
      cycles($urandom_range(0, 30));
    end

    // Timeouts until retry_count saturates.
    pll_locked = 1'b0;
    cycles(17 * (RST_PULSE + TIMEOUT) + 10);
    check("retry_saturated", retry_count, 4'd15);

    // Asynchronous reset in the middle of STABLE.
    pll_locked = 1'b1;
    wait_settle(-1, 200, "reach_settle_for_rst");
    @(posedge refclk);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_outputs", observed(), 8'hC0);
    cycles(2);
    rst = 1'b0;
    wait_until(SEL_READY, 1'b1, 40, "ready_after_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Controls the fabric PLL's reset and consumes its `locked` output on the reference-clock side.
- Pulses the PLL reset at start-up, waits for lock, and requires lock to stay stable before releasing the core reset to logic clocked by the PLL outputs.
- Watches for loss of lock and for lock timeouts, and re-runs the PLL reset sequence when either occurs.
- Sits between the top-level reset/reference clock and the PLL wrapper plus core reset distribution.

Parameters:
- RST_PULSE_CYCLES, 16, number of refclk cycles `pll_rst` is held high per reset attempt (>=2).
- LOCK_STABLE_CYCLES, 1024, consecutive refclk cycles the synchronized lock must stay high before release (>=2).
- LOCK_TIMEOUT_CYCLES, 262144, refclk cycles allowed in WAIT_LOCK before a retry (>=4).
- CNT_W, 20, cycle-counter width; must hold max(all three parameters)-1.

Ports:
- refclk  in  1  reference clock; all logic is clocked here.
- rst  in  1  asynchronous, active-high reset.
- pll_locked  in  1  PLL lock flag; asynchronous to refclk.
- force_relock  in  1  synchronous request to restart the sequence; level, sampled each cycle.
- pll_rst  out  1  reset to the PLL, active high.
- core_rst  out  1  reset to downstream core logic, active high.
- ready  out  1  high while the sequencer is in RUN.
- lock_lost  out  1  one-cycle pulse when lock drops while in RUN.
- retry_count  out  4  number of timeout retries; saturates at 15.

Behaviour:
- Reset is asynchronous and active-high. While `rst`=1:
  - state=PLL_RESET, counter=0, sync flops=0.
  - pll_rst=1, core_rst=1, ready=0, lock_lost=0, retry_count=0.
- All outputs are registered.
- `pll_locked` passes through a 2-flop synchronizer to give `locked_s`, which lags `pll_locked` by 2 cycles. The FSM uses only `locked_s`.
- PLL_RESET state:
  - pll_rst=1, core_rst=1, ready=0.
  - Counter increments each cycle; when counter==RST_PULSE_CYCLES-1, clear the counter and go to WAIT_LOCK.
  - `pll_rst` is therefore high for exactly RST_PULSE_CYCLES cycles after rst release or after a retry.
- WAIT_LOCK state:
  - pll_rst=0, core_rst=1.
  - If locked_s=1: go to STABLE and clear the counter.
  - Else if counter==LOCK_TIMEOUT_CYCLES-1: increment retry_count (saturating at 15), clear the counter, go to PLL_RESET.
  - Otherwise increment the counter.
- STABLE state:
  - pll_rst=0, core_rst=1.
  - If locked_s=0: go to WAIT_LOCK and clear the counter; retry_count is unchanged and the timeout window restarts.
  - Else if counter==LOCK_STABLE_CYCLES-1: go to RUN.
  - Otherwise increment the counter.
- RUN state:
  - core_rst=0 and ready=1, both registered so they change on the edge that enters RUN.
  - If locked_s=0: lock_lost=1 for one cycle, core_rst=1 and ready=0 on the same edge, clear the counter, go to PLL_RESET.
- force_relock:
  - In any state other than PLL_RESET, force_relock=1 sends the FSM to PLL_RESET on the next edge, clears the counter, sets core_rst=1 and ready=0.
  - Force has priority over every other transition.
  - lock_lost is not pulsed for a forced relock, and retry_count is not incremented.
  - Asserting force_relock while already in PLL_RESET has no effect; the pulse count continues.
- Simultaneous events:
  - Lock drop and force_relock on the same edge in RUN: force wins, lock_lost=0.
  - Timeout and force_relock on the same edge in WAIT_LOCK: force wins, no increment.
- retry_count is cleared only by rst.
- Glitches on pll_locked shorter than one cycle may be missed. Any synchronized low in STABLE restarts the stability window.
- Asserting rst mid-sequence returns all outputs to their reset values immediately (asynchronously).

Test Plan (RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32):
- Power-up, clean lock: release rst, drive pll_locked=1 five cycles after pll_rst falls → pll_rst high exactly 4 cycles; ready and core_rst change 2+8 cycles after pll_locked rises (±1 per the FSM entry edge); retry_count=0.
- Timeout: hold pll_locked=0 → pll_rst re-pulses for 4 cycles every 36 cycles; retry_count steps 1, 2, 3… and sticks at 15 after 15 timeouts.
- Unstable lock: in STABLE, drop pll_locked for 2 cycles at stability count 5 → returns to WAIT_LOCK; RUN is reached only after a further 8 clean cycles; retry_count unchanged.
- Lock loss in RUN: drop pll_locked → lock_lost high for exactly 1 cycle, 3 edges after the drop; core_rst=1 and ready=0 on that edge; pll_rst pulses for 4 cycles.
- force_relock in RUN and in WAIT_LOCK, each coincident with a lock drop or timeout → PLL_RESET next edge; lock_lost=0; retry_count unchanged. force_relock held in PLL_RESET → pulse still exactly 4 cycles.
- Async reset mid-STABLE: assert rst between clock edges → pll_rst=1, core_rst=1, ready=0, retry_count=0 without waiting for a clock edge.
